// File: rtl/write_back_stage.sv
// write_back_stage: final pipeline stage, selects ALU/memory data and gathers vector loads
module write_back_stage #(
    parameter int WORD     = 32,
    parameter int LANES    = 8,
    parameter bit ZERO_REG = 1'b1,
    parameter int VEC      = WORD * LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             WriteRegister_MEM,
    input  logic             WriteRegisterVec_MEM,
    input  logic             SelWriteData_MEM,
    input  logic [4:0]       Rd_MEM,
    input  logic [VEC-1:0]   ALUResult_MEM,
    input  logic [WORD-1:0]  mem_rdata,
    input  logic             mem_rvalid,
    output logic             WRITEREGISTER_WB,
    output logic             WRITEREGISTERVEC_WB,
    output logic [4:0]       RD_WB,
    output logic [VEC-1:0]   INPUTDATA,
    output logic             stall_wb
);
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] GATHER = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    logic [0:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [4:0]     r_rd;
    logic [VEC-1:0] r_buf;
    logic           r_wr;
    logic           r_wrv;
    logic [4:0]     r_rd_wb;
    logic [VEC-1:0] r_data;
    logic [VEC-1:0] w_buf_nx;
    logic           w_scalar_ok;

    // gather buffer with the incoming beat dropped into the current lane
    always_comb begin
        w_buf_nx = r_buf;
        w_buf_nx[r_cnt * WORD +: WORD] = mem_rdata;
    end

    // scalar write allowed: data available and not targeting a hardwired zero register
    always_comb begin
        w_scalar_ok = (!SelWriteData_MEM || mem_rvalid) && !(ZERO_REG && Rd_MEM == 5'd0);
    end

    // FSM, gather buffer and registered write-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_buf   <= '0;
            r_wr    <= 1'b0;
            r_wrv   <= 1'b0;
            r_rd_wb <= '0;
            r_data  <= '0;
        end else begin
            r_wr  <= 1'b0;
            r_wrv <= 1'b0;
            if (r_state == IDLE) begin
                if (in_valid && WriteRegisterVec_MEM) begin
                    if (SelWriteData_MEM) begin
                        r_rd    <= Rd_MEM;
                        r_cnt   <= '0;
                        r_state <= GATHER;
                    end else begin
                        r_wrv   <= 1'b1;
                        r_rd_wb <= Rd_MEM;
                        r_data  <= ALUResult_MEM;
                    end
                end else if (in_valid && WriteRegister_MEM && w_scalar_ok) begin
                    r_wr    <= 1'b1;
                    r_rd_wb <= Rd_MEM;
                    r_data  <= {{(VEC-WORD){1'b0}}, SelWriteData_MEM ? mem_rdata : ALUResult_MEM[WORD-1:0]};
                end
            end else if (mem_rvalid) begin
                r_buf <= w_buf_nx;
                if (r_cnt == LAST) begin
                    r_cnt   <= '0;
                    r_wrv   <= 1'b1;
                    r_rd_wb <= r_rd;
                    r_data  <= w_buf_nx;
                    r_state <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign WRITEREGISTER_WB    = r_wr;
    assign WRITEREGISTERVEC_WB = r_wrv;
    assign RD_WB               = r_rd_wb;
    assign INPUTDATA           = r_data;
    assign stall_wb            = r_state;
endmodule

// File: tb/tb_write_back_stage.sv
// tb_write_back_stage: vector table, gather sequences and random model check for write_back_stage
module tb_write_back_stage;
    localparam int WORD  = 32;
    localparam int LANES = 8;
    localparam int VEC   = WORD * LANES;

    localparam logic [VEC-1:0] A1 = {{7{32'hCAFEF00D}}, 32'h1234ABCD};
    localparam logic [VEC-1:0] A2 = {{7{32'h89ABCDEF}}, 32'h00C0FFEE};
    localparam logic [VEC-1:0] V1 = {8{32'h01020304}};
    localparam logic [VEC-1:0] Z1 = {224'b0, 32'h1234ABCD};
    localparam logic [VEC-1:0] Z2 = {224'b0, 32'h00C0FFEE};
    localparam logic [VEC-1:0] ZA = {224'b0, 32'hA5A5A5A5};
    localparam logic [VEC-1:0] ONES = {VEC{1'b1}};

    logic clk = 1'b0;
    logic rst;
    logic in_valid, wr_m, wrv_m, sel_m, mv;
    logic [4:0] rd_m;
    logic [VEC-1:0] alu;
    logic [WORD-1:0] md;
    logic o_wr, o_wrv, o_stall;
    logic [4:0] o_rd;
    logic [VEC-1:0] o_data;

    int checks = 0;
    int failures = 0;

    write_back_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .WriteRegister_MEM(wr_m), .WriteRegisterVec_MEM(wrv_m), .SelWriteData_MEM(sel_m),
        .Rd_MEM(rd_m), .ALUResult_MEM(alu), .mem_rdata(md), .mem_rvalid(mv),
        .WRITEREGISTER_WB(o_wr), .WRITEREGISTERVEC_WB(o_wrv), .RD_WB(o_rd),
        .INPUTDATA(o_data), .stall_wb(o_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iv, wr, wv, sel;
        logic [4:0] rd;
        logic [VEC-1:0] alu;
        logic [31:0] md;
        logic mv;
        logic ewr, ewv;
        logic [4:0] erd;
        logic [VEC-1:0] edat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [VEC-1:0] act, input logic [VEC-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; wr_m = 1'b0; wrv_m = 1'b0; sel_m = 1'b0;
        rd_m = '0; alu = '0; md = '0; mv = 1'b0;
    endtask

    task automatic start_vload(input logic [4:0] rd);
        idle_in();
        in_valid = 1'b1; wrv_m = 1'b1; sel_m = 1'b1; rd_m = rd;
        tick();
        idle_in();
        chk("vload_accept_stall", VEC'(o_stall), VEC'(1));
        chk("vload_accept_nostrobe", VEC'({o_wr, o_wrv}), VEC'(0));
    endtask

    // gather 8 beats (k+1)*0x11 with gap[k] idle cycles before beat k
    task automatic gather(input logic [4:0] rd, input int g0, input int g1, input int exp_stall);
        int gap[LANES];
        int stall_cnt;
        logic [VEC-1:0] exp;
        gap = '{default: 0};
        gap[2] = g0; gap[5] = g1;
        exp = '0;
        stall_cnt = 0;
        start_vload(rd);
        stall_cnt += int'(o_stall);
        for (int k = 0; k < LANES; k++) begin
            for (int g = 0; g < gap[k]; g++) begin
                mv = 1'b0; md = 32'hBADBAD00;
                in_valid = 1'b1; wr_m = 1'b1; rd_m = 5'd2; alu = A1;
                tick();
                chk("gap_nostrobe", VEC'({o_wr, o_wrv}), VEC'(0));
                stall_cnt += int'(o_stall);
            end
            idle_in();
            mv = 1'b1; md = 32'((k + 1) * 32'h11);
            exp[k*WORD +: WORD] = md;
            tick();
            if (k < LANES - 1) begin
                chk("beat_nostrobe", VEC'({o_wr, o_wrv}), VEC'(0));
                stall_cnt += int'(o_stall);
            end
        end
        idle_in();
        chk("commit_wrv", VEC'(o_wrv), VEC'(1));
        chk("commit_stall_low", VEC'(o_stall), VEC'(0));
        chk("commit_rd", VEC'(o_rd), VEC'(rd));
        chk("commit_data", o_data, exp);
        chk("stall_cycles", VEC'(stall_cnt), VEC'(exp_stall));
        tick();
        chk("commit_single_pulse", VEC'(o_wrv), VEC'(0));
    endtask

    // reference model state
    logic m_gath;
    logic [4:0] m_lrd, m_rd;
    logic [VEC-1:0] m_data;
    logic [WORD-1:0] m_q[$];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd5,  A1, 32'h0,        1'b0, 1'b1, 1'b0, 5'd5,  Z1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  A1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd5,  Z1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd12, A1, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 5'd12, ZA};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd13, A1, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 5'd12, ZA};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd20, A1, 32'h0,        1'b0, 1'b0, 1'b0, 5'd12, ZA};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd21, A1, 32'h0,        1'b1, 1'b0, 1'b0, 5'd12, ZA};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  V1, 32'h0,        1'b0, 1'b0, 1'b1, 5'd0,  V1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd9,  A1, 32'h0,        1'b0, 1'b0, 1'b1, 5'd9,  A1};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd31, A2, 32'h77777777, 1'b1, 1'b1, 1'b0, 5'd31, Z2};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  V1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd31, Z2};

        idle_in();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset_wr", VEC'(o_wr), VEC'(0));
        chk("reset_wrv", VEC'(o_wrv), VEC'(0));
        chk("reset_rd", VEC'(o_rd), VEC'(0));
        chk("reset_data", o_data, '0);
        chk("reset_stall", VEC'(o_stall), VEC'(0));

        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].iv; wr_m = tbl[i].wr; wrv_m = tbl[i].wv; sel_m = tbl[i].sel;
            rd_m = tbl[i].rd; alu = tbl[i].alu; md = tbl[i].md; mv = tbl[i].mv;
            tick();
            chk($sformatf("tbl%0d_wr", i), VEC'(o_wr), VEC'(tbl[i].ewr));
            chk($sformatf("tbl%0d_wrv", i), VEC'(o_wrv), VEC'(tbl[i].ewv));
            chk($sformatf("tbl%0d_rd", i), VEC'(o_rd), VEC'(tbl[i].erd));
            chk($sformatf("tbl%0d_data", i), o_data, tbl[i].edat);
            chk($sformatf("tbl%0d_stall", i), VEC'(o_stall), VEC'(0));
        end
        idle_in();
        tick();

        gather(5'd3, 0, 0, 8);
        gather(5'd17, 3, 3, 14);

        // reset in the middle of a gather, then a vector ALU op
        start_vload(5'd4);
        for (int k = 0; k < 4; k++) begin
            mv = 1'b1; md = 32'(k + 100);
            tick();
        end
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_stall", VEC'(o_stall), VEC'(0));
        chk("midrst_strobes", VEC'({o_wr, o_wrv}), VEC'(0));
        chk("midrst_data", o_data, '0);
        in_valid = 1'b1; wrv_m = 1'b1; rd_m = 5'd7; alu = ONES;
        tick();
        idle_in();
        chk("post_rst_wrv", VEC'(o_wrv), VEC'(1));
        chk("post_rst_rd", VEC'(o_rd), VEC'(7));
        chk("post_rst_data", o_data, ONES);
        chk("post_rst_stall", VEC'(o_stall), VEC'(0));

        // randomized stream against a queue-based model
        m_gath = 1'b0; m_rd = 5'd7; m_data = ONES; m_lrd = '0; m_q = {};
        for (int n = 0; n < 600; n++) begin
            logic ewr, ewv;
            in_valid = ($urandom_range(0, 1) == 1);
            wr_m = ($urandom_range(0, 2) != 0);
            wrv_m = ($urandom_range(0, 3) == 0);
            sel_m = ($urandom_range(0, 1) == 1);
            rd_m = 5'($urandom_range(0, 31));
            for (int w = 0; w < LANES; w++) alu[w*WORD +: WORD] = $urandom;
            md = $urandom;
            mv = ($urandom_range(0, 9) < 6);
            ewr = 1'b0; ewv = 1'b0;
            if (!m_gath) begin
                if (in_valid && wrv_m) begin
                    if (sel_m) begin
                        m_gath = 1'b1; m_lrd = rd_m; m_q = {};
                    end else begin
                        ewv = 1'b1; m_rd = rd_m; m_data = alu;
                    end
                end else if (in_valid && wr_m && (!sel_m || mv) && rd_m != 5'd0) begin
                    ewr = 1'b1; m_rd = rd_m;
                    m_data = VEC'(sel_m ? md : alu[WORD-1:0]);
                end
            end else if (mv) begin
                m_q.push_back(md);
                if (m_q.size() == LANES) begin
                    for (int k = 0; k < LANES; k++) m_data[k*WORD +: WORD] = m_q[k];
                    ewv = 1'b1; m_rd = m_lrd; m_gath = 1'b0;
                end
            end
            tick();
            chk("rnd_wr", VEC'(o_wr), VEC'(ewr));
            chk("rnd_wrv", VEC'(o_wrv), VEC'(ewv));
            chk("rnd_rd", VEC'(o_rd), VEC'(m_rd));
            chk("rnd_data", o_data, m_data);
            chk("rnd_stall", VEC'(o_stall), VEC'(m_gath));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
